// File: rtl/shft_pkg.sv
// Shared definitions for the sequenced shift datapath.
//  - state_e : controller state encoding (IDLE, SHIFT, DONE)
//  - DIR_LEFT / DIR_RIGHT : values of the direction bit
package shft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shft_step.sv
// Combinational single-position shifter.
//  d     in  WIDTH  word to shift
//  dir   in  1      DIR_LEFT / DIR_RIGHT
//  arith in  1      right shift only: replicate MSB instead of zero fill
//  q     out WIDTH  word shifted by one position
module shft_step
  import shft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      q = {d[WIDTH-2:0], 1'b0};
    end else begin
      q = {arith & d[WIDTH-1], d[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shft_seq_ctrl.sv
// Sequencing controller for a multi-bit shift built from a 1-bit shift stage.
// Accepts one command over cmd_valid/cmd_ready, steps the working word one
// position per clock, and offers the result over res_valid/res_ready.
//  clk, reset  clock and synchronous active-high reset
//  cmd_valid   in   command present
//  cmd_ready   out  controller idle and able to accept
//  cmd_data    in   word to shift
//  cmd_dir     in   1 = left, 0 = right
//  cmd_amt     in   shift amount; values above WIDTH behave as WIDTH
//  cmd_arith   in   right shift: 1 = sign fill, 0 = zero fill
//  res_valid   out  result available (held until res_ready)
//  res_ready   in   consumer takes the result
//  res_data    out  shifted word, stable while res_valid
//  busy        out  high whenever not IDLE
module shft_seq_ctrl
  import shft_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_arith,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  // Shifting by WIDTH already gives all-fill, so larger amounts are clamped
  // to keep the SHIFT phase bounded at WIDTH cycles.
  function automatic logic [AMT_W-1:0] sat_amt(input logic [AMT_W-1:0] a);
    return (a > AMT_MAX) ? AMT_MAX : a;
  endfunction

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] step_q;
  logic [AMT_W-1:0] amt_eff;

  shft_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .d    (work_q),
    .dir  (dir_q),
    .arith(arith_q),
    .q    (step_q)
  );

  assign amt_eff = sat_amt(cmd_amt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          arith_d = cmd_arith;
          if (amt_eff == '0) begin
            res_d   = cmd_data;
            state_d = DONE;
          end else begin
            work_d  = cmd_data;
            cnt_d   = amt_eff;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_q;
        cnt_d  = cnt_q - AMT_ONE;
        // The last step lands directly in the result register so res_data
        // never shows intermediate words.
        if (cnt_q == AMT_ONE) begin
          res_d   = step_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Working word and latched command fields are only meaningful in SHIFT,
  // where they are always freshly loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    work_q  <= work_d;
    dir_q   <= dir_d;
    arith_q <= arith_d;
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_q;

endmodule

// File: tb/tb_shft_seq_ctrl.sv
module tb_shft_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_dir;
  logic [3:0] cmd_amt;
  logic       cmd_arith;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] data;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic       prev_v = 1'b0;
  logic [7:0] held;

  shft_seq_ctrl #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_dir  (cmd_dir),
    .cmd_amt  (cmd_amt),
    .cmd_arith(cmd_arith),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference using native shift operators.
  function automatic logic [7:0] model(input logic [7:0] d, input logic dir,
                                       input logic [3:0] amt, input logic arith);
    int n;
    n = (amt > 4'd8) ? 8 : int'(amt);
    if (dir) return d << n;
    if (arith) return 8'($signed(d) >>> n);
    return d >> n;
  endfunction

  // Monitor: on each rising res_valid pop the scoreboard; latency is counted
  // in clock edges after the accept edge. While res_valid stays high the
  // word must not change.
  always @(negedge clk) begin
    exp_t it;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (res_valid && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_res", 32'(res_valid), 32'd0);
        end else begin
          it = sb.pop_front();
          chk("res_data", 32'(res_data), 32'(it.data));
          chk("latency", 32'(cyc - it.acc), 32'(it.lat));
          held = res_data;
        end
      end else if (res_valid && prev_v) begin
        chk("res_hold", 32'(res_data), 32'(held));
      end
      prev_v = res_valid;
    end
  end

  task automatic send(input logic [7:0] d, input logic dir, input logic [3:0] amt,
                      input logic arith, input logic [7:0] exp, input bit push);
    exp_t it;
    bit   done;
    done      = 1'b0;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_amt   = amt;
    cmd_arith = arith;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (cmd_ready) begin
        // Accept happens on the coming posedge, which bumps cyc.
        it.data = exp;
        it.lat  = (amt > 4'd8) ? 8 : int'(amt);
        it.acc  = cyc + 1;
        if (push) sb.push_back(it);
        done = 1'b1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    else begin
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       dir, ar;
    logic [3:0] amt;
    bit         waited;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_amt   = '0;
    cmd_arith = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    send(8'h81, 1'b1, 4'd3, 1'b0, 8'h08, 1'b1); drain();
    send(8'h90, 1'b0, 4'd2, 1'b1, 8'hE4, 1'b1); drain();
    send(8'h90, 1'b0, 4'd2, 1'b0, 8'h24, 1'b1); drain();
    send(8'h5A, 1'b1, 4'd0, 1'b0, 8'h5A, 1'b1); drain();
    send(8'hFF, 1'b1, 4'd12, 1'b0, 8'h00, 1'b1); drain();
    send(8'h96, 1'b0, 4'd15, 1'b1, 8'hFF, 1'b1); drain();
    send(8'h96, 1'b0, 4'd8, 1'b0, 8'h00, 1'b1); drain();
    send(8'h01, 1'b1, 4'd7, 1'b0, 8'h80, 1'b1); drain();
    send(8'hC3, 1'b0, 4'd1, 1'b1, 8'hE1, 1'b1); drain();

    for (int k = 0; k < 20; k++) begin
      d   = 8'($urandom);
      dir = 1'($urandom);
      amt = 4'($urandom_range(0, 15));
      ar  = 1'($urandom);
      send(d, dir, amt, ar, model(d, dir, amt, ar), 1'b1);
      drain();
    end

    // Backpressure: result held in DONE while commands are refused.
    res_ready = 1'b0;
    send(8'h3C, 1'b0, 4'd1, 1'b0, 8'h1E, 1'b1);
    waited = 1'b0;
    for (int i = 0; i < 20 && !waited; i++) begin
      if (res_valid) waited = 1'b1;
      else @(negedge clk);
    end
    chk("bp_reach_done", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 8'($urandom);
      cmd_amt   = 4'd2;
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
    chk("bp_idle_valid", 32'(res_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during the 2nd SHIFT cycle of an amt=6 command.
    send(8'hA5, 1'b1, 4'd6, 1'b0, 8'h40, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("mid_rst_no_result", 32'(res_valid), 32'd0);
    chk("mid_rst_data_late", 32'(res_data), 32'd0);

    // Controller must still work after the abort.
    send(8'h0F, 1'b1, 4'd4, 1'b0, 8'hF0, 1'b1); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
